// File: rtl/assoc_read_cache_if.sv
// rtl/assoc_read_cache_if.sv - CPU request and memory refill bus of the set-associative read cache
interface assoc_read_cache_if #(
    parameter int ADDR_W          = 15,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4
);
    logic                              cpu_read;
    logic [ADDR_W-1:0]                 cpu_address;
    logic                              flush;
    logic                              cpu_ready;
    logic [WORD_W-1:0]                 cpu_data_out;
    logic                              hit;
    logic                              mem_read;
    logic [ADDR_W-1:0]                 mem_address;
    logic                              mem_ready;
    logic [WORDS_PER_BLOCK*WORD_W-1:0] mem_data;
    logic [15:0]                       hit_count;
    logic [15:0]                       access_count;

    // master: CPU plus backing memory; slave: the cache
    modport master (
        output cpu_read, cpu_address, flush, mem_ready, mem_data,
        input  cpu_ready, cpu_data_out, hit, mem_read, mem_address, hit_count, access_count
    );

    modport slave (
        input  cpu_read, cpu_address, flush, mem_ready, mem_data,
        output cpu_ready, cpu_data_out, hit, mem_read, mem_address, hit_count, access_count
    );
endinterface

// File: rtl/assoc_read_cache.sv
// rtl/assoc_read_cache.sv - N-way set-associative read cache, round-robin refill; CACHE_STATS_EN adds hit/access counters
module assoc_read_cache #(
    parameter int ADDR_W          = 15,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int SETS            = 512,
    parameter int WAYS            = 2
) (
    input  logic               clk,
    input  logic               rst,
    assoc_read_cache_if.slave  bus
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W = WORDS_PER_BLOCK * WORD_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [SETS-1:0][WAYS-1:0]      valid_q, valid_d;
    logic [SETS-1:0][WAY_W-1:0]     ptr_q, ptr_d;
    logic                           cpu_ready_q, cpu_ready_d;
    logic                           hit_q, hit_d;
    logic [WORD_W-1:0]              rdata_q, rdata_d;
    logic                           mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;

    logic [TAG_W-1:0]               tag_mem  [SETS][WAYS];
    logic [BLK_W-1:0]               data_mem [SETS][WAYS];

    logic [TAG_W-1:0]               cur_tag;
    logic [IDX_W-1:0]               cur_idx;
    logic [OFF_W-1:0]               cur_off;
    logic                           lookup_hit;
    logic [WAY_W-1:0]               hit_way;
    logic [WORD_W-1:0]              hit_word;
    logic [WORD_W-1:0]              fill_word;
    logic                           any_invalid;
    logic [WAY_W-1:0]               victim;
    logic                           fill_we;

    assign cur_tag = addr_q[ADDR_W-1 -: TAG_W];
    assign cur_idx = addr_q[OFF_W +: IDX_W];
    assign cur_off = addr_q[OFF_W-1:0];

    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[cur_idx][w] && (tag_mem[cur_idx][w] == cur_tag)) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins; fall back to the pointer way
    always_comb begin
        any_invalid = 1'b0;
        victim      = ptr_q[cur_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[cur_idx][w]) begin
                any_invalid = 1'b1;
                victim      = WAY_W'(w);
            end
        end
    end

    always_comb begin
        hit_word  = '0;
        fill_word = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            if (cur_off == OFF_W'(k)) begin
                hit_word  = data_mem[cur_idx][hit_way][k*WORD_W +: WORD_W];
                fill_word = bus.mem_data[k*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        ptr_d       = ptr_q;
        cpu_ready_d = 1'b0;
        hit_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_read_d  = mem_read_q;
        mem_addr_d  = mem_addr_q;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                    ptr_d   = '0;
                end else if (bus.cpu_read) begin
                    addr_d  = bus.cpu_address;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    rdata_d     = hit_word;
                    cpu_ready_d = 1'b1;
                    hit_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    mem_read_d = 1'b1;
                    mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_ready) begin
                    fill_we                  = 1'b1;
                    valid_d[cur_idx][victim] = 1'b1;
                    if (!any_invalid) begin
                        ptr_d[cur_idx] = (WAYS == 1) ? '0 : ptr_q[cur_idx] + WAY_W'(1);
                    end
                    mem_read_d  = 1'b0;
                    rdata_d     = fill_word;
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            valid_q     <= '0;
            ptr_q       <= '0;
            cpu_ready_q <= 1'b0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            ptr_q       <= ptr_d;
            cpu_ready_q <= cpu_ready_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
        end
        // Tag and data arrays carry no reset; the valid bits qualify them
        if (rst && fill_we) begin
            tag_mem[cur_idx][victim]  <= cur_tag;
            data_mem[cur_idx][victim] <= bus.mem_data;
        end
    end

    assign bus.cpu_ready    = cpu_ready_q;
    assign bus.hit          = hit_q;
    assign bus.cpu_data_out = rdata_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_address  = mem_addr_q;

`ifdef CACHE_STATS_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] hits_q, hits_d;

    // Both counters stop together once the access count saturates
    always_comb begin
        acc_d  = acc_q;
        hits_d = hits_q;
        if (state_q == IDLE && bus.flush) begin
            acc_d  = '0;
            hits_d = '0;
        end else if (state_q == LOOKUP && acc_q != 16'hFFFF) begin
            acc_d = acc_q + 16'd1;
            if (lookup_hit) begin
                hits_d = hits_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            hits_q <= '0;
        end else begin
            acc_q  <= acc_d;
            hits_q <= hits_d;
        end
    end

    assign bus.access_count = acc_q;
    assign bus.hit_count    = hits_q;
`else
    assign bus.access_count = '0;
    assign bus.hit_count    = '0;
`endif
endmodule

// File: tb/tb_assoc_read_cache.sv
// tb/tb_assoc_read_cache.sv - directed self-checking bench for assoc_read_cache
module tb_assoc_read_cache;
    localparam int ADDR_W = 15;
    localparam int WORD_W = 32;
    localparam int WPB    = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    assoc_read_cache_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_BLOCK(WPB)) bus ();

    assoc_read_cache #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_BLOCK(WPB), .SETS(512), .WAYS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: every word holds a marker plus its own word address
    function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h5A00_0000 | {17'd0, a};
    endfunction

    function automatic logic [WPB*WORD_W-1:0] mem_block(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] base;
        base = {a[ADDR_W-1:2], 2'b00};
        return {mem_word(base + 15'd3), mem_word(base + 15'd2),
                mem_word(base + 15'd1), mem_word(base)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.cpu_read = 1'b0;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic read_req(input string tag, input logic [ADDR_W-1:0] a,
                            input logic exp_hit, input int delay);
        bus.cpu_address = a;
        bus.cpu_read = 1'b1;
        tick();
        chk({tag, ".rdy_e0"}, 64'(bus.cpu_ready), 64'd0);
        tick();
        if (exp_hit) begin
            chk({tag, ".hit_rdy"}, 64'(bus.cpu_ready), 64'd1);
            chk({tag, ".hit"}, 64'(bus.hit), 64'd1);
            chk({tag, ".hit_memrd"}, 64'(bus.mem_read), 64'd0);
            chk({tag, ".hit_data"}, 64'(bus.cpu_data_out), 64'(mem_word(a)));
        end else begin
            chk({tag, ".miss_rdy"}, 64'(bus.cpu_ready), 64'd0);
            chk({tag, ".memrd"}, 64'(bus.mem_read), 64'd1);
            chk({tag, ".memaddr"}, 64'(bus.mem_address), 64'({a[ADDR_W-1:2], 2'b00}));
            for (int i = 0; i < delay; i++) begin
                tick();
                chk({tag, ".memrd_hold"}, 64'(bus.mem_read), 64'd1);
                chk({tag, ".rdy_wait"}, 64'(bus.cpu_ready), 64'd0);
            end
            bus.mem_data = mem_block(a);
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            bus.mem_data = '0;
            chk({tag, ".fill_rdy"}, 64'(bus.cpu_ready), 64'd1);
            chk({tag, ".fill_hit"}, 64'(bus.hit), 64'd0);
            chk({tag, ".fill_data"}, 64'(bus.cpu_data_out), 64'(mem_word(a)));
            chk({tag, ".fill_memrd"}, 64'(bus.mem_read), 64'd0);
        end
        bus.cpu_read = 1'b0;
        tick();
        chk({tag, ".pulse"}, 64'(bus.cpu_ready), 64'd0);
        chk({tag, ".data_hold"}, 64'(bus.cpu_data_out), 64'(mem_word(a)));
    endtask

    task automatic chk_stats(input string tag, input logic [15:0] acc, input logic [15:0] hits);
`ifdef CACHE_STATS_EN
        chk({tag, ".acc"}, 64'(bus.access_count), 64'(acc));
        chk({tag, ".hits"}, 64'(bus.hit_count), 64'(hits));
`else
        chk({tag, ".acc_tied"}, 64'(bus.access_count), 64'd0);
        chk({tag, ".hits_tied"}, 64'(bus.hit_count), 64'd0);
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.cpu_read = 1'b0;
        bus.cpu_address = '0;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_data = '0;
        do_reset();

        chk("rst.rdy", 64'(bus.cpu_ready), 64'd0);
        chk("rst.hit", 64'(bus.hit), 64'd0);
        chk("rst.memrd", 64'(bus.mem_read), 64'd0);
        chk("rst.data", 64'(bus.cpu_data_out), 64'd0);
        chk("rst.memaddr", 64'(bus.mem_address), 64'd0);
        chk_stats("rst", 16'd0, 16'd0);

        read_req("cold", 15'h0000, 1'b0, 0);
        read_req("hit2", 15'h0002, 1'b1, 0);
        read_req("hit3", 15'h0003, 1'b1, 0);
        chk_stats("after_hits", 16'd3, 16'd2);

        // Stray mem_ready in IDLE must do nothing
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("stray.rdy", 64'(bus.cpu_ready), 64'd0);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_stats("flush", 16'd0, 16'd0);
        read_req("postflush", 15'h0002, 1'b0, 2);

        do_reset();
        read_req("rr_a", 15'h0000, 1'b0, 1);
        read_req("rr_b", 15'h0800, 1'b0, 0);
        read_req("rr_c", 15'h1000, 1'b0, 3);
        read_req("rr_b_hit", 15'h0801, 1'b1, 0);
        read_req("rr_a_evicted", 15'h0000, 1'b0, 0);
        read_req("rr_c_hit", 15'h1002, 1'b1, 0);
        read_req("rr_b_evicted", 15'h0800, 1'b0, 0);
        read_req("other_set", 15'h0005, 1'b0, 0);
        read_req("other_hit", 15'h0007, 1'b1, 0);
        chk_stats("rr", 16'd9, 16'd3);

        do_reset();
        read_req("st_miss", 15'h0000, 1'b0, 0);
        read_req("st_hit1", 15'h0001, 1'b1, 0);
        read_req("st_hit3", 15'h0003, 1'b1, 0);
        chk_stats("stats", 16'd3, 16'd2);

        // Reset while the refill is outstanding
        bus.cpu_address = 15'h0010;
        bus.cpu_read = 1'b1;
        tick();
        tick();
        chk("mid.memrd_before", 64'(bus.mem_read), 64'd1);
        rst = 1'b0;
        bus.cpu_read = 1'b0;
        tick();
        chk("mid.memrd", 64'(bus.mem_read), 64'd0);
        chk("mid.memaddr", 64'(bus.mem_address), 64'd0);
        chk("mid.data", 64'(bus.cpu_data_out), 64'd0);
        chk_stats("mid", 16'd0, 16'd0);
        rst = 1'b1;
        bus.mem_data = mem_block(15'h0010);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("late.rdy", 64'(bus.cpu_ready), 64'd0);
        chk("late.memrd", 64'(bus.mem_read), 64'd0);
        read_req("after_rst", 15'h0010, 1'b0, 0);
        read_req("after_rst_old", 15'h0000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
